id_ex_operand_stage: RTL

- Pipeline register between decode and the ALU.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages and selects the immediate for operand B.
- Detects load-use hazards and inserts bubbles.
- Registers the ALU inputs (Ain, Bin, ALUop) and destination info; the ALU consumes the registered outputs combinationally in the following cycle.

---
 rtl/id_ex_operand_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves EX/MEM and MEM/WB forwarding, selects operand B,
// detects load-use hazards and registers the ALU inputs plus destination info.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [RIDX-1:0] id_rs1,
  input  logic [RIDX-1:0] id_rs2,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_aluop,
  input  logic [RIDX-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            exm_regwrite,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output logic            hazard,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_ain,
  output logic [XLEN-1:0] ex_bin,
  output logic [XLEN-1:0] ex_store_data,
  output logic [3:0]      ex_aluop,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_is_load
);

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_ain_q, ex_ain_d;
  logic [XLEN-1:0] ex_bin_q, ex_bin_d;
  logic [XLEN-1:0] ex_store_data_q, ex_store_data_d;
  logic [3:0]      ex_aluop_q, ex_aluop_d;
  logic [RIDX-1:0] ex_rd_q, ex_rd_d;
  logic            ex_regwrite_q, ex_regwrite_d;
  logic            ex_is_load_q, ex_is_load_d;

  // EX/MEM is younger than MEM/WB, so it is checked first; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = id_rs1_data;
    if (exm_regwrite && exm_rd == id_rs1 && id_rs1 != '0)
      fwd_rs1 = exm_result;
    else if (mwb_regwrite && mwb_rd == id_rs1 && id_rs1 != '0)
      fwd_rs1 = mwb_result;

    fwd_rs2 = id_rs2_data;
    if (exm_regwrite && exm_rd == id_rs2 && id_rs2 != '0)
      fwd_rs2 = exm_result;
    else if (mwb_regwrite && mwb_rd == id_rs2 && id_rs2 != '0)
      fwd_rs2 = mwb_result;
  end

  assign hazard = id_valid && ex_valid_q && ex_is_load_q && ex_rd_q != '0 &&
                  (ex_rd_q == id_rs1 || (id_uses_rs2 && ex_rd_q == id_rs2));

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_ain_d        = ex_ain_q;
    ex_bin_d        = ex_bin_q;
    ex_store_data_d = ex_store_data_q;
    ex_aluop_d      = ex_aluop_q;
    ex_rd_d         = ex_rd_q;
    ex_regwrite_d   = ex_regwrite_q;
    ex_is_load_d    = ex_is_load_q;
    // A hazard bubble is identical to a flush; stall only wins over the hazard.
    if (flush || (!stall && hazard)) begin
      ex_valid_d      = 1'b0;
      ex_ain_d        = '0;
      ex_bin_d        = '0;
      ex_store_data_d = '0;
      ex_aluop_d      = '0;
      ex_rd_d         = '0;
      ex_regwrite_d   = 1'b0;
      ex_is_load_d    = 1'b0;
    end else if (!stall) begin
      ex_valid_d      = id_valid;
      ex_ain_d        = fwd_rs1;
      ex_bin_d        = id_use_imm ? id_imm : fwd_rs2;
      ex_store_data_d = fwd_rs2;
      ex_aluop_d      = id_aluop;
      ex_rd_d         = id_rd;
      ex_regwrite_d   = id_regwrite && id_valid;
      ex_is_load_d    = id_is_load && id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_ain_q        <= '0;
      ex_bin_q        <= '0;
      ex_store_data_q <= '0;
      ex_aluop_q      <= '0;
      ex_rd_q         <= '0;
      ex_regwrite_q   <= 1'b0;
      ex_is_load_q    <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_ain_q        <= ex_ain_d;
      ex_bin_q        <= ex_bin_d;
      ex_store_data_q <= ex_store_data_d;
      ex_aluop_q      <= ex_aluop_d;
      ex_rd_q         <= ex_rd_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_is_load_q    <= ex_is_load_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_ain        = ex_ain_q;
  assign ex_bin        = ex_bin_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_aluop      = ex_aluop_q;
  assign ex_rd         = ex_rd_q;
  assign ex_regwrite   = ex_regwrite_q;
  assign ex_is_load    = ex_is_load_q;

endmodule
